// File: rtl/multi_port_ram_driver_pkg.sv
// Shared constants and elaboration-time helpers for multi_port_ram_driver and its arbiter.
// Width helpers are pure constant functions so they can size ports and localparams.
package multi_port_ram_driver_pkg;

  localparam int SHARED_RAM_SIZE    = 4096;
  localparam int SHARED_RAM_LATENCY = 2;
  localparam int SHARED_RAM_READERS = 2;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Channel tag width: one bit minimum so a single reader still has a tag field.
  function automatic int tagWidth(input int n);
    int bits;
    bits = clog2(n);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/multi_port_ram_driver_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping modulo N.
// The pointer moves past the winner only when the grant is actually taken (advance).
module rr_arbiter
  import multi_port_ram_driver_pkg::*;
#(
  parameter int N = 2,
  localparam int WW = tagWidth(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [WW-1:0] winner
);

  localparam logic [WW-1:0] LAST = WW'(N - 1);

  logic [WW-1:0] r_ptr;
  logic          w_found;

  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    winner  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!w_found && req[idx]) begin
        w_found    = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx[WW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (winner == LAST) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/multi_port_ram_driver.sv
// Shared-RAM driver: one write port, NUM_READERS round-robin read channels, tagged read pipeline.
// Optional macro RAM_DRIVER_STATS_EN adds read_count and contention_count outputs.
module multi_port_ram_driver
  import multi_port_ram_driver_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_SIZE     = SHARED_RAM_SIZE,
  parameter int READ_LATENCY = SHARED_RAM_LATENCY,
  parameter int NUM_READERS  = SHARED_RAM_READERS,
  localparam int AW = clog2(RAM_SIZE),
  localparam int TW = tagWidth(NUM_READERS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_READERS-1:0]    read_req,
  input  logic [NUM_READERS*AW-1:0] read_addr,
  output logic [NUM_READERS-1:0]    read_grant,
  input  logic                      write_enable,
  input  logic [AW-1:0]             write_addr,
  input  logic [DATA_WIDTH-1:0]     write_val,
  output logic [NUM_READERS-1:0]    read_ready,
  output logic [DATA_WIDTH-1:0]     read_out
`ifdef RAM_DRIVER_STATS_EN
  ,
  output logic [31:0]               read_count,
  output logic [31:0]               contention_count
`endif
);

  localparam logic [AW:0] RAM_WORDS = (AW + 1)'(RAM_SIZE);

  logic [DATA_WIDTH-1:0]  r_mem [RAM_SIZE];
  logic                   r_vld [READ_LATENCY];
  logic [TW-1:0]          r_tag [READ_LATENCY];
  logic [DATA_WIDTH-1:0]  r_dat [READ_LATENCY];

  logic [NUM_READERS-1:0] w_arb_grant;
  logic [TW-1:0]          w_winner;
  logic                   w_accept;
  logic [AW-1:0]          w_rd_addr;
  logic                   w_rd_in_range;
  logic                   w_wr_in_range;
  logic [DATA_WIDTH-1:0]  w_rd_data;

  // The pointer only advances while out of reset, since grants are masked during reset.
  rr_arbiter #(
    .N(NUM_READERS)
  ) u_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (read_req),
    .advance (reset_n),
    .grant   (w_arb_grant),
    .winner  (w_winner)
  );

  assign read_grant    = reset_n ? w_arb_grant : '0;
  assign w_accept      = |read_grant;
  assign w_rd_addr     = read_addr[int'(w_winner)*AW +: AW];
  assign w_rd_in_range = ({1'b0, w_rd_addr} < RAM_WORDS);
  assign w_wr_in_range = ({1'b0, write_addr} < RAM_WORDS);

  // Write-first on a same-cycle address match; out-of-range reads return zero.
  always_comb begin
    w_rd_data = '0;
    if (w_rd_in_range) begin
      if (write_enable && w_wr_in_range && (write_addr == w_rd_addr)) begin
        w_rd_data = write_val;
      end else begin
        w_rd_data = r_mem[w_rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (write_enable && w_wr_in_range) begin
      r_mem[write_addr] <= write_val;
    end
  end

  // Data and tag only move with a valid entry, so the last stage holds read_out between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_vld[k] <= 1'b0;
        r_tag[k] <= '0;
        r_dat[k] <= '0;
      end
    end else begin
      r_vld[0] <= w_accept;
      if (w_accept) begin
        r_tag[0] <= w_winner;
        r_dat[0] <= w_rd_data;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_tag[k] <= r_tag[k-1];
          r_dat[k] <= r_dat[k-1];
        end
      end
    end
  end

  assign read_ready = r_vld[READ_LATENCY-1] ?
                      (NUM_READERS'(1) << r_tag[READ_LATENCY-1]) : '0;
  assign read_out   = r_dat[READ_LATENCY-1];

`ifdef RAM_DRIVER_STATS_EN
  logic w_multi_req;

  assign w_multi_req = |(read_req & (read_req - NUM_READERS'(1)));

  // Grant count wraps naturally; contention count sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_count       <= '0;
      contention_count <= '0;
    end else begin
      if (w_accept) begin
        read_count <= read_count + 32'd1;
      end
      if (w_multi_req && (contention_count != '1)) begin
        contention_count <= contention_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_port_ram_driver.sv
// Bench for multi_port_ram_driver: a default instance (2 readers, latency 2) and a 4-reader,
// latency-1, 3000-word instance, checked by directed vectors and a behavioural model.
module tb_multi_port_ram_driver;

  localparam int NA   = 2;
  localparam int LA   = 2;
  localparam int SA   = 4096;
  localparam int NB   = 4;
  localparam int LB   = 1;
  localparam int SB   = 3000;
  localparam int AW   = 12;
  localparam int MAXC = 2048;

  typedef struct {
    logic [1:0]    req;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wv;
    logic [1:0]    eGrant;
    logic [1:0]    eReady;
    logic [7:0]    eOut;
  } vecT;

  logic clk;
  logic resetN;

  logic [NA-1:0]    reqA, grantA, readyA;
  logic [NA*AW-1:0] addrA;
  logic             weA;
  logic [AW-1:0]    waA;
  logic [7:0]       wvA, outA;

  logic [NB-1:0]    reqB, grantB, readyB;
  logic [NB*AW-1:0] addrB;
  logic             weB;
  logic [AW-1:0]    waB;
  logic [7:0]       wvB, outB;

`ifdef RAM_DRIVER_STATS_EN
  logic [31:0] rcA, ccA, rcB, ccB;
`endif

  int nCompared;
  int nMismatched;
  int cyc;

  int         ptr       [2];
  logic [7:0] expGrant  [2];
  logic [7:0] lastOut   [2];
  bit         lastKnown [2];
  logic [7:0] sRdy      [2][MAXC];
  logic [7:0] sDat      [2][MAXC];
  bit         sKnown    [2][MAXC];
  logic [7:0] mdlMem    [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multi_port_ram_driver #(
    .DATA_WIDTH(8), .RAM_SIZE(SA), .READ_LATENCY(LA), .NUM_READERS(NA)
  ) dutA (
    .clk(clk), .reset_n(resetN), .read_req(reqA), .read_addr(addrA), .read_grant(grantA),
    .write_enable(weA), .write_addr(waA), .write_val(wvA), .read_ready(readyA), .read_out(outA)
`ifdef RAM_DRIVER_STATS_EN
    , .read_count(rcA), .contention_count(ccA)
`endif
  );

  multi_port_ram_driver #(
    .DATA_WIDTH(8), .RAM_SIZE(SB), .READ_LATENCY(LB), .NUM_READERS(NB)
  ) dutB (
    .clk(clk), .reset_n(resetN), .read_req(reqB), .read_addr(addrB), .read_grant(grantB),
    .write_enable(weB), .write_addr(waB), .write_val(wvB), .read_ready(readyB), .read_out(outB)
`ifdef RAM_DRIVER_STATS_EN
    , .read_count(rcB), .contention_count(ccB)
`endif
  );

  function automatic int nOf(input int d);
    return (d == 0) ? NA : NB;
  endfunction

  function automatic int lOf(input int d);
    return (d == 0) ? LA : LB;
  endfunction

  function automatic int sizeOf(input int d);
    return (d == 0) ? SA : SB;
  endfunction

  function automatic logic [4*AW-1:0] packAddr(input int a0, input int a1, input int a2, input int a3);
    logic [4*AW-1:0] p;
    p = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    return p;
  endfunction

  task automatic compareValue(input string name, input int d, input logic [31:0] act,
                              input logic [31:0] want);
    nCompared++;
    if (act !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got 0x%0h, wanted 0x%0h", name, d, cyc, act, want);
    end
  endtask

  // Drives one DUT's inputs for this cycle and advances the reference model.
  task automatic applyStimulus(input int d, input logic [7:0] req, input logic [4*AW-1:0] addrs,
                               input logic we, input logic [AW-1:0] wa, input logic [7:0] wv);
    int g, c, slot, key;
    logic [AW-1:0] ra;
    g = -1;
    if (d == 0) begin
      reqA = req[NA-1:0]; addrA = addrs[NA*AW-1:0]; weA = we; waA = wa; wvA = wv;
    end else begin
      reqB = req[NB-1:0]; addrB = addrs[NB*AW-1:0]; weB = we; waB = wa; wvB = wv;
    end
    if (resetN) begin
      for (int k = 0; k < nOf(d); k++) begin
        c = (ptr[d] + k) % nOf(d);
        if (g < 0 && req[c]) g = c;
      end
    end
    expGrant[d] = '0;
    if (g >= 0) begin
      expGrant[d][g] = 1'b1;
      ra   = addrs[g*AW +: AW];
      slot = cyc + lOf(d);
      key  = d * 8192 + int'(ra);
      sRdy[d][slot]   = expGrant[d];
      sKnown[d][slot] = 1'b1;
      if (int'(ra) >= sizeOf(d)) sDat[d][slot] = 8'h00;
      else if (we && wa == ra) sDat[d][slot] = wv;
      else if (mdlMem.exists(key)) sDat[d][slot] = mdlMem[key];
      else sKnown[d][slot] = 1'b0;
      ptr[d] = (g + 1) % nOf(d);
    end
    if (we && int'(wa) < sizeOf(d)) mdlMem[d * 8192 + int'(wa)] = wv;
    if (!resetN) begin
      for (int s = cyc; s < MAXC; s++) sRdy[d][s] = '0;
      ptr[d]       = 0;
      lastOut[d]   = 8'h00;
      lastKnown[d] = 1'b1;
    end
  endtask

  task automatic checkOutput(input int d);
    logic [7:0] g, r, o;
    g = '0;
    r = '0;
    if (d == 0) begin
      g[NA-1:0] = grantA; r[NA-1:0] = readyA; o = outA;
    end else begin
      g[NB-1:0] = grantB; r[NB-1:0] = readyB; o = outB;
    end
    compareValue("grant", d, 32'(g), 32'(expGrant[d]));
    compareValue("ready", d, 32'(r), 32'(sRdy[d][cyc]));
    if (sRdy[d][cyc] != '0) begin
      if (sKnown[d][cyc]) compareValue("rdata", d, 32'(o), 32'(sDat[d][cyc]));
      lastOut[d]   = sDat[d][cyc];
      lastKnown[d] = sKnown[d][cyc];
    end else if (lastKnown[d]) begin
      compareValue("hold", d, 32'(o), 32'(lastOut[d]));
    end
  endtask

  task automatic sampleBoth();
    @(negedge clk);
    checkOutput(0);
    checkOutput(1);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idleA();
    applyStimulus(0, 8'h00, '0, 1'b0, '0, 8'h00);
  endtask

  task automatic idleB();
    applyStimulus(1, 8'h00, '0, 1'b0, '0, 8'h00);
  endtask

  function automatic logic [AW-1:0] randAddrB();
    if ($urandom_range(0, 9) == 0) return AW'($urandom_range(2990, 4095));
    return AW'($urandom_range(0, 63));
  endfunction

  initial begin
    vecT tbl [18];
    logic [4*AW-1:0] ad;
    logic [4*AW-1:0] adB;

    tbl[0]  = '{2'b00, 12'd0,  12'd0,  1'b1, 12'd10, 8'hA5, 2'b00, 2'b00, 8'h00};
    tbl[1]  = '{2'b01, 12'd10, 12'd0,  1'b0, 12'd0,  8'h00, 2'b01, 2'b00, 8'h00};
    tbl[2]  = '{2'b00, 12'd0,  12'd0,  1'b0, 12'd0,  8'h00, 2'b00, 2'b00, 8'h00};
    tbl[3]  = '{2'b00, 12'd0,  12'd0,  1'b0, 12'd0,  8'h00, 2'b00, 2'b01, 8'hA5};
    tbl[4]  = '{2'b10, 12'd0,  12'd10, 1'b0, 12'd0,  8'h00, 2'b10, 2'b00, 8'hA5};
    tbl[5]  = '{2'b11, 12'd10, 12'd10, 1'b0, 12'd0,  8'h00, 2'b01, 2'b00, 8'hA5};
    tbl[6]  = '{2'b11, 12'd10, 12'd10, 1'b0, 12'd0,  8'h00, 2'b10, 2'b10, 8'hA5};
    tbl[7]  = '{2'b11, 12'd10, 12'd10, 1'b0, 12'd0,  8'h00, 2'b01, 2'b01, 8'hA5};
    tbl[8]  = '{2'b11, 12'd10, 12'd10, 1'b0, 12'd0,  8'h00, 2'b10, 2'b10, 8'hA5};
    tbl[9]  = '{2'b00, 12'd0,  12'd0,  1'b0, 12'd0,  8'h00, 2'b00, 2'b01, 8'hA5};
    tbl[10] = '{2'b00, 12'd0,  12'd0,  1'b0, 12'd0,  8'h00, 2'b00, 2'b10, 8'hA5};
    tbl[11] = '{2'b00, 12'd0,  12'd0,  1'b1, 12'd5,  8'h11, 2'b00, 2'b00, 8'hA5};
    tbl[12] = '{2'b10, 12'd0,  12'd5,  1'b1, 12'd5,  8'h22, 2'b10, 2'b00, 8'hA5};
    tbl[13] = '{2'b00, 12'd0,  12'd0,  1'b1, 12'd5,  8'h33, 2'b00, 2'b00, 8'hA5};
    tbl[14] = '{2'b00, 12'd0,  12'd0,  1'b0, 12'd0,  8'h00, 2'b00, 2'b10, 8'h22};
    tbl[15] = '{2'b01, 12'd5,  12'd0,  1'b0, 12'd0,  8'h00, 2'b01, 2'b00, 8'h22};
    tbl[16] = '{2'b00, 12'd0,  12'd0,  1'b0, 12'd0,  8'h00, 2'b00, 2'b00, 8'h22};
    tbl[17] = '{2'b00, 12'd0,  12'd0,  1'b0, 12'd0,  8'h00, 2'b00, 2'b01, 8'h33};

    nCompared   = 0;
    nMismatched = 0;
    cyc         = 0;
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0; expGrant[d] = '0; lastOut[d] = 8'h00; lastKnown[d] = 1'b1;
      for (int s = 0; s < MAXC; s++) begin
        sRdy[d][s] = '0; sDat[d][s] = '0; sKnown[d][s] = 1'b0;
      end
    end

    // Reset state: requests present but no grant, no ready, zero data.
    resetN = 1'b1;
    #2 resetN = 1'b0;
    applyStimulus(0, 8'h03, '0, 1'b0, '0, 8'h00);
    applyStimulus(1, 8'h0F, '0, 1'b0, '0, 8'h00);
    sampleBoth();
    nextCycle();
    resetN = 1'b1;

    foreach (tbl[i]) begin
      ad = packAddr(int'(tbl[i].a0), int'(tbl[i].a1), 0, 0);
      applyStimulus(0, {6'b0, tbl[i].req}, ad, tbl[i].we, tbl[i].wa, tbl[i].wv);
      idleB();
      sampleBoth();
      compareValue("tblGrant", 0, 32'(grantA), 32'(tbl[i].eGrant));
      compareValue("tblReady", 0, 32'(readyA), 32'(tbl[i].eReady));
      compareValue("tblOut", 0, 32'(outA), 32'(tbl[i].eOut));
      nextCycle();
    end

    // A granted read is dropped by a one-cycle reset; pointer returns to channel 0.
    applyStimulus(0, 8'h01, packAddr(5, 0, 0, 0), 1'b0, '0, 8'h00);
    idleB();
    sampleBoth();
    nextCycle();
    resetN = 1'b0;
    idleA();
    idleB();
    sampleBoth();
    compareValue("rstReady", 0, 32'(readyA), 32'd0);
    compareValue("rstOut", 0, 32'(outA), 32'd0);
    nextCycle();
    resetN = 1'b1;
    idleA();
    idleB();
    sampleBoth();
    compareValue("dropReady", 0, 32'(readyA), 32'd0);
    nextCycle();
    applyStimulus(0, 8'h03, packAddr(5, 5, 0, 0), 1'b0, '0, 8'h00);
    idleB();
    sampleBoth();
    compareValue("ptrGrant", 0, 32'(grantA), 32'd1);
    nextCycle();
    idleA();
    idleB();
    sampleBoth();
    nextCycle();
    idleA();
    idleB();
    sampleBoth();
    compareValue("rereadRdy", 0, 32'(readyA), 32'd1);
    compareValue("rereadOut", 0, 32'(outA), 32'h33);
    nextCycle();

    // Randomised traffic on both instances against the model.
    for (int n = 0; n < 500; n++) begin
      ad  = packAddr($urandom_range(0, 63), $urandom_range(0, 63), 0, 0);
      adB = {randAddrB(), randAddrB(), randAddrB(), randAddrB()};
      applyStimulus(0, 8'($urandom_range(0, 3)), ad, 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
      applyStimulus(1, 8'($urandom_range(0, 15)), adB, 1'($urandom_range(0, 1)),
                    randAddrB(), 8'($urandom_range(0, 255)));
      sampleBoth();
      nextCycle();
    end

    // Last valid word, then a read of the first out-of-range address.
    idleA();
    applyStimulus(1, 8'h00, '0, 1'b1, 12'd2999, 8'h5C);
    sampleBoth();
    nextCycle();
    idleA();
    applyStimulus(1, 8'h08, packAddr(0, 0, 0, 2999), 1'b0, '0, 8'h00);
    sampleBoth();
    nextCycle();
    idleA();
    applyStimulus(1, 8'h04, packAddr(0, 0, 3000, 0), 1'b1, 12'd3000, 8'h7E);
    sampleBoth();
    compareValue("lastReady", 1, 32'(readyB), 32'h8);
    compareValue("lastOut", 1, 32'(outB), 32'h5C);
    nextCycle();
    idleA();
    idleB();
    sampleBoth();
    compareValue("oorReady", 1, 32'(readyB), 32'h4);
    compareValue("oorOut", 1, 32'(outB), 32'h0);
    nextCycle();

`ifdef RAM_DRIVER_STATS_EN
    resetN = 1'b0;
    idleA();
    idleB();
    sampleBoth();
    nextCycle();
    resetN = 1'b1;
    for (int n = 0; n < 6; n++) begin
      applyStimulus(0, (n < 4) ? 8'h03 : 8'h01, packAddr(10, 10, 0, 0), 1'b0, '0, 8'h00);
      idleB();
      sampleBoth();
      nextCycle();
    end
    idleA();
    idleB();
    sampleBoth();
    compareValue("readCount", 0, rcA, 32'd6);
    compareValue("contention", 0, ccA, 32'd4);
    nextCycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
